// File: rtl/mc6809_pkg.sv
// Shared definitions for the MC6809 DMA arbiter: FSM state codes,
// BA/BS bus status decoding and the shared counter width.
package mc6809_pkg;

    // Arbiter FSM encoding, kept as plain constants so older blocks can reuse it.
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_REQ     = 2'd1;
    localparam logic [1:0] ARB_GRANT   = 2'd2;
    localparam logic [1:0] ARB_RELEASE = 2'd3;

    // One counter is reused for burst length, release gap and ack timeout.
    localparam int CNT_W = 5;

    // grant_id is always presented as 3 bits, whatever NREQ is.
    localparam int GRANT_ID_W = 3;

    // CPU bus status as reported on {BA, BS}.
    typedef enum logic [1:0] {
        BUS_RUN   = 2'b00,
        BUS_IACK  = 2'b01,
        BUS_SYNC  = 2'b10,
        BUS_GRANT = 2'b11
    } bus_status_e;

    function automatic bus_status_e decode_status(input logic ba, input logic bs);
        return bus_status_e'({ba, bs});
    endfunction

endpackage

// File: rtl/mc6809_dma_arbiter_if.sv
// Bus-side signals of the DMA arbiter. The arbiter takes the master view
// (it owns the grants and nDMABREQ); the CPU wrapper and requesters take the slave view.
interface mc6809_dma_arbiter_if
    import mc6809_pkg::*;
#(
    parameter int NREQ = 4
) ();
    logic                  i_e;
    logic                  i_ba;
    logic                  i_bs;
    logic [NREQ-1:0]       i_req;
    logic [NREQ-1:0]       o_grant;
    logic [GRANT_ID_W-1:0] o_grant_id;
    logic                  o_bus_owned;
    logic                  o_ndmabreq;
    logic                  o_tmo_err;

    modport master (
        input  i_e, i_ba, i_bs, i_req,
        output o_grant, o_grant_id, o_bus_owned, o_ndmabreq, o_tmo_err
    );

    modport slave (
        output i_e, i_ba, i_bs, i_req,
        input  o_grant, o_grant_id, o_bus_owned, o_ndmabreq, o_tmo_err
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or after the pointer, wrapping at NREQ, plus a flag saying any was found.
module rr_pick
    import mc6809_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_winner,
    output logic            o_any
);
    logic [IDW-1:0] w_idx;

    // Walk the requesters starting at the pointer and latch onto the first hit.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = i_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any && i_req[w_idx]) begin
                o_any    = 1'b1;
                o_winner = w_idx;
            end
            w_idx = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
        end
    end
endmodule

// File: rtl/mc6809_dma_arbiter.sv
// MC6809 DMA arbiter: requests the bus from the CPU with nDMABREQ, waits for
// BA&BS, then grants one requester at a time round-robin for bounded bursts
// measured in E cycles, with a forced gap so the CPU always makes progress.
module mc6809_dma_arbiter
    import mc6809_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 14,
    parameter int MIN_GAP   = 2,
    parameter int ACK_TMO   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mc6809_dma_arbiter_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] C_BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST   = CNT_W'(ACK_TMO - 1);
    localparam logic [IDW-1:0]   C_IDX_LAST   = IDW'(NREQ - 1);

    logic             r_e_q;
    logic             r_ack_q;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_idx;
    logic [NREQ-1:0]  r_grant;
    logic             r_bus_owned;
    logic             r_ndmabreq;
    logic             r_tmo_err;

    logic             w_e_fall;
    logic             w_ack;
    logic [IDW-1:0]   w_winner;
    logic             w_any;
    logic [NREQ-1:0]  w_onehot;
    logic             w_req_granted;
    logic [IDW-1:0]   w_next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req    (bus.i_req),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_e_fall      = r_e_q & ~bus.i_e;
    assign w_ack         = (decode_status(bus.i_ba, bus.i_bs) == BUS_GRANT);
    assign w_onehot      = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_req_granted = bus.i_req[r_grant_idx];
    assign w_next_ptr    = (r_grant_idx == C_IDX_LAST) ? '0 : r_grant_idx + IDW'(1);

    // Delay E and BA&BS by one clock; E falls and the CPU ack are only ever used in this form.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_q   <= 1'b0;
            r_ack_q <= 1'b0;
        end else begin
            r_e_q   <= bus.i_e;
            r_ack_q <= w_ack;
        end
    end

    // Bus-request FSM with the shared burst/gap/timeout counter; all E counting is on E falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_grant     <= '0;
            r_bus_owned <= 1'b0;
            r_ndmabreq  <= 1'b1;
            r_tmo_err   <= 1'b0;
        end else begin
            r_tmo_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (|bus.i_req) begin
                        r_ndmabreq <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (r_ack_q && w_any) begin
                        r_grant     <= w_onehot;
                        r_grant_idx <= w_winner;
                        r_bus_owned <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ARB_GRANT;
                    end else if (!w_any) begin
                        r_ndmabreq <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ARB_RELEASE;
                    end else if (w_e_fall) begin
                        if (r_cnt == C_TMO_LAST) begin
                            r_tmo_err  <= 1'b1;
                            r_ndmabreq <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ARB_RELEASE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ARB_GRANT: begin
                    if (!r_ack_q ||
                        (w_e_fall && ((r_cnt == C_BURST_LAST) || !w_req_granted))) begin
                        r_grant     <= '0;
                        r_bus_owned <= 1'b0;
                        r_ndmabreq  <= 1'b1;
                        r_rr_ptr    <= w_next_ptr;
                        r_cnt       <= '0;
                        r_state     <= ARB_RELEASE;
                    end else if (w_e_fall) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ARB_RELEASE: begin
                    if (w_e_fall && !r_ack_q) begin
                        if (r_cnt == C_GAP_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ARB_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.o_grant     = r_grant;
    assign bus.o_grant_id  = GRANT_ID_W'(r_grant_idx);
    assign bus.o_bus_owned = r_bus_owned;
    assign bus.o_ndmabreq  = r_ndmabreq;
    assign bus.o_tmo_err   = r_tmo_err;
endmodule

// File: tb/tb_mc6809_dma_arbiter.sv
// Testbench for mc6809_dma_arbiter: a free-running E clock and a simple CPU
// model that answers nDMABREQ with BA/BS, plus a queue of expected grants
// filled as requests are raised and drained as grants appear.
module tb_mc6809_dma_arbiter;

    localparam int NREQ       = 4;
    localparam int MAX_BURST  = 14;
    localparam int MIN_GAP    = 2;
    localparam int ACK_TMO    = 16;
    localparam int WAIT_LIMIT = 2000;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            e     = 1'b0;
    logic            ba    = 1'b0;
    logic            bs    = 1'b0;
    logic [NREQ-1:0] req   = '0;

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  efall_cnt    = 0;
    int  e_div        = 0;
    int  ack_wait     = 0;
    int  ack_delay    = 2;
    int  model_ptr    = 0;
    bit  e_run        = 1'b1;
    bit  cpu_auto     = 1'b1;
    bit  man_ba       = 1'b0;
    bit  man_bs       = 1'b0;
    logic e_last      = 1'b0;

    logic [NREQ-1:0] exp_q[$];

    mc6809_dma_arbiter_if #(.NREQ(NREQ)) bus ();

    assign bus.i_e   = e;
    assign bus.i_ba  = ba;
    assign bus.i_bs  = bs;
    assign bus.i_req = req;

    mc6809_dma_arbiter #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST),
        .MIN_GAP   (MIN_GAP),
        .ACK_TMO   (ACK_TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // System clock, 10 time units per period.
    always #5 clk = ~clk;

    // E clock (8 CLK period), E-fall bookkeeping and the CPU's BA/BS response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (e_last && !e) begin
                efall_cnt++;
                if (cpu_auto && !bus.o_ndmabreq) ack_wait++;
            end
            e_last = e;
            if (cpu_auto) begin
                if (bus.o_ndmabreq) begin
                    ba = 1'b0;
                    bs = 1'b0;
                    ack_wait = 0;
                end else if (ack_wait >= ack_delay) begin
                    ba = 1'b1;
                    bs = 1'b1;
                end
            end else begin
                ba = man_ba;
                bs = man_bs;
            end
            if (e_run) begin
                e_div++;
                if (e_div == 4) begin
                    e_div = 0;
                    e = ~e;
                end
            end
        end
    end

    function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (r[idx]) return NREQ'(1) << idx;
        end
        return '0;
    endfunction

    function automatic int oh2idx(input logic [NREQ-1:0] oh);
        for (int k = 0; k < NREQ; k++) if (oh[k]) return k;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_efalls(input int n);
        int start;
        int guard;
        start = efall_cnt;
        guard = 0;
        while (efall_cnt < start + n && guard < WAIT_LIMIT) begin
            tick();
            guard++;
        end
    endtask

    task automatic wait_owned(input logic val, output bit timed_out);
        int guard;
        guard = 0;
        while (bus.o_bus_owned !== val && guard < WAIT_LIMIT) begin
            tick();
            guard++;
        end
        timed_out = (bus.o_bus_owned !== val);
    endtask

    task automatic wait_breq(input logic val, output bit timed_out);
        int guard;
        guard = 0;
        while (bus.o_ndmabreq !== val && guard < WAIT_LIMIT) begin
            tick();
            guard++;
        end
        timed_out = (bus.o_ndmabreq !== val);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        model_ptr = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.o_grant !== '0) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b want 0000", bus.o_grant); end
        tests_run++;
        if (bus.o_grant_id !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_grant_id: got %0d want 0", bus.o_grant_id); end
        tests_run++;
        if (bus.o_bus_owned !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bus_owned: got %b want 0", bus.o_bus_owned); end
        tests_run++;
        if (bus.o_ndmabreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ndmabreq: got %b want 1", bus.o_ndmabreq); end
        tests_run++;
        if (bus.o_tmo_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tmo_err: got %b want 0", bus.o_tmo_err); end
        rst_n = 1'b1;
        tick();
        model_ptr = 0;
    endtask

    task automatic test_single_burst();
        bit to;
        int start;
        int n;
        logic [NREQ-1:0] expv;
        cpu_auto = 1'b1;
        exp_q.push_back(model_pick(4'b0001, model_ptr));
        req = 4'b0001;
        wait_breq(1'b0, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL single_breq_low: got %b want 0", bus.o_ndmabreq); end
        wait_owned(1'b1, to);
        expv = '0;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        tests_run++;
        if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL single_grant: got %b want %b", bus.o_grant, expv); end
        tests_run++;
        if (bus.o_grant_id !== 3'(oh2idx(expv))) begin tests_failed++; $display("[TB] FAIL single_grant_id: got %0d want %0d", bus.o_grant_id, oh2idx(expv)); end
        model_ptr = (oh2idx(expv) + 1) % NREQ;
        start = efall_cnt;
        wait_owned(1'b0, to);
        n = efall_cnt - start;
        tests_run++;
        if (to || n != MAX_BURST) begin tests_failed++; $display("[TB] FAIL single_burst_len: got %0d E falls want %0d", n, MAX_BURST); end
        tests_run++;
        if (bus.o_ndmabreq !== 1'b1 || bus.o_grant !== '0) begin tests_failed++; $display("[TB] FAIL single_release: ndmabreq %b grant %b want 1 0000", bus.o_ndmabreq, bus.o_grant); end
        start = efall_cnt;
        wait_breq(1'b0, to);
        n = efall_cnt - start;
        tests_run++;
        if (to || n < MIN_GAP || n > MIN_GAP + 1) begin tests_failed++; $display("[TB] FAIL single_gap: got %0d E falls want %0d..%0d", n, MIN_GAP, MIN_GAP + 1); end
        req = '0;
        tick();
        tick();
        tests_run++;
        if (bus.o_ndmabreq !== 1'b1 || bus.o_bus_owned !== 1'b0) begin tests_failed++; $display("[TB] FAIL abandon_in_req: ndmabreq %b owned %b want 1 0", bus.o_ndmabreq, bus.o_bus_owned); end
        wait_efalls(4);
    endtask

    task automatic test_round_robin();
        bit to;
        bit stable;
        logic [NREQ-1:0] expv;
        logic [NREQ-1:0] first;
        int guard;
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            exp_q.push_back(model_pick(req, model_ptr));
            wait_owned(1'b1, to);
            expv = '0;
            if (exp_q.size() > 0) expv = exp_q.pop_front();
            tests_run++;
            if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL rr_grant_%0d: got %b want %b", b, bus.o_grant, expv); end
            model_ptr = (oh2idx(expv) + 1) % NREQ;
            first = bus.o_grant;
            stable = 1'b1;
            guard = 0;
            while (bus.o_bus_owned === 1'b1 && guard < WAIT_LIMIT) begin
                tick();
                guard++;
                if (bus.o_bus_owned === 1'b1 && bus.o_grant !== first) stable = 1'b0;
            end
            tests_run++;
            if (!stable || guard >= WAIT_LIMIT) begin tests_failed++; $display("[TB] FAIL rr_stable_%0d: got %b want %b held", b, bus.o_grant, first); end
            tests_run++;
            if (bus.o_ndmabreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_gap_%0d: ndmabreq %b want 1", b, bus.o_ndmabreq); end
        end
        req = '0;
        wait_efalls(4);
    endtask

    task automatic test_req_drop();
        bit to;
        int start;
        int n;
        logic [NREQ-1:0] expv;
        exp_q.push_back(model_pick(4'b0100, model_ptr));
        req = 4'b0100;
        wait_owned(1'b1, to);
        expv = '0;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        tests_run++;
        if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL drop_grant: got %b want %b", bus.o_grant, expv); end
        model_ptr = (oh2idx(expv) + 1) % NREQ;
        wait_efalls(3);
        req = '0;
        tick();
        tests_run++;
        if (bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL drop_hold_until_efall: got %b want %b", bus.o_grant, expv); end
        start = efall_cnt;
        wait_owned(1'b0, to);
        n = efall_cnt - start;
        tests_run++;
        if (to || n != 1) begin tests_failed++; $display("[TB] FAIL drop_exit_efall: got %0d E falls want 1", n); end
        exp_q.push_back(model_pick(4'b1001, model_ptr));
        req = 4'b1001;
        wait_owned(1'b1, to);
        expv = '0;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        tests_run++;
        if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL drop_rr_ptr_grant: got %b want %b", bus.o_grant, expv); end
        tests_run++;
        if (bus.o_grant_id !== 3'(oh2idx(expv))) begin tests_failed++; $display("[TB] FAIL drop_rr_ptr_id: got %0d want %0d", bus.o_grant_id, oh2idx(expv)); end
        model_ptr = (oh2idx(expv) + 1) % NREQ;
        req = '0;
        wait_owned(1'b0, to);
        wait_efalls(4);
    endtask

    task automatic test_timeout();
        bit to;
        bit bad;
        int start;
        int n;
        int guard;
        cpu_auto = 1'b0;
        man_ba = 1'b0;
        man_bs = 1'b0;
        req = 4'b0001;
        wait_breq(1'b0, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL tmo_breq_low: got %b want 0", bus.o_ndmabreq); end
        start = efall_cnt;
        bad = 1'b0;
        guard = 0;
        while (bus.o_tmo_err !== 1'b1 && guard < WAIT_LIMIT) begin
            tick();
            guard++;
            if (bus.o_bus_owned !== 1'b0) bad = 1'b1;
        end
        n = efall_cnt - start;
        tests_run++;
        if (bus.o_tmo_err !== 1'b1 || n != ACK_TMO) begin tests_failed++; $display("[TB] FAIL tmo_length: tmo %b after %0d E falls want 1 after %0d", bus.o_tmo_err, n, ACK_TMO); end
        tests_run++;
        if (bad || bus.o_ndmabreq !== 1'b1 || bus.o_bus_owned !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_abort: ndmabreq %b owned %b stray %b want 1 0 0", bus.o_ndmabreq, bus.o_bus_owned, bad); end
        tick();
        tests_run++;
        if (bus.o_tmo_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_pulse_width: got %b want 0", bus.o_tmo_err); end
        req = '0;
        man_ba = 1'b1;
        man_bs = 1'b1;
        bad = 1'b0;
        repeat (60) begin
            tick();
            if (bus.o_bus_owned !== 1'b0 || bus.o_ndmabreq !== 1'b1) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("[TB] FAIL unsolicited_ack: owned %b ndmabreq %b want 0 1", bus.o_bus_owned, bus.o_ndmabreq); end
        man_ba = 1'b0;
        man_bs = 1'b0;
        tick();
        cpu_auto = 1'b1;
        wait_efalls(4);
    endtask

    task automatic test_ack_drop();
        bit to;
        int n;
        logic [NREQ-1:0] expv;
        exp_q.push_back(model_pick(4'b0010, model_ptr));
        req = 4'b0010;
        wait_owned(1'b1, to);
        expv = '0;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        tests_run++;
        if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL ackdrop_grant: got %b want %b", bus.o_grant, expv); end
        model_ptr = (oh2idx(expv) + 1) % NREQ;
        wait_efalls(2);
        man_ba = 1'b0;
        man_bs = 1'b1;
        cpu_auto = 1'b0;
        tick();
        n = 0;
        while (bus.o_bus_owned === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 2) begin tests_failed++; $display("[TB] FAIL ackdrop_latency: got %0d CLK want 2", n); end
        tests_run++;
        if (bus.o_grant !== '0 || bus.o_ndmabreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL ackdrop_release: grant %b ndmabreq %b want 0000 1", bus.o_grant, bus.o_ndmabreq); end
        man_bs = 1'b0;
        req = '0;
        tick();
        cpu_auto = 1'b1;
        wait_efalls(4);
    endtask

    task automatic test_reset_mid_grant();
        bit to;
        logic [NREQ-1:0] expv;
        exp_q.push_back(model_pick(4'b0010, model_ptr));
        req = 4'b0010;
        wait_owned(1'b1, to);
        expv = '0;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        tests_run++;
        if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL midreset_pre_grant: got %b want %b", bus.o_grant, expv); end
        wait_efalls(2);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.o_grant !== '0 || bus.o_ndmabreq !== 1'b1 || bus.o_bus_owned !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async: grant %b ndmabreq %b owned %b want 0000 1 0", bus.o_grant, bus.o_ndmabreq, bus.o_bus_owned);
        end
        model_ptr = 0;
        // requester 1 is still pending; requester 2 is added so a stale pointer would pick it instead
        req = 4'b0110;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_q.push_back(model_pick(req, model_ptr));
        wait_owned(1'b1, to);
        expv = '0;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        tests_run++;
        if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL midreset_regrant: got %b want %b", bus.o_grant, expv); end
        tests_run++;
        if (bus.o_grant_id !== 3'(oh2idx(expv))) begin tests_failed++; $display("[TB] FAIL midreset_regrant_id: got %0d want %0d", bus.o_grant_id, oh2idx(expv)); end
        model_ptr = (oh2idx(expv) + 1) % NREQ;
        req = '0;
        wait_owned(1'b0, to);
        wait_efalls(4);
    endtask

    task automatic test_e_freeze();
        bit to;
        bit dropped;
        int start;
        int n;
        logic [NREQ-1:0] expv;
        exp_q.push_back(model_pick(4'b0001, model_ptr));
        req = 4'b0001;
        wait_owned(1'b1, to);
        expv = '0;
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        tests_run++;
        if (to || bus.o_grant !== expv) begin tests_failed++; $display("[TB] FAIL freeze_grant: got %b want %b", bus.o_grant, expv); end
        wait_efalls(5);
        e_run = 1'b0;
        dropped = 1'b0;
        repeat (200) begin
            tick();
            if (bus.o_bus_owned !== 1'b1) dropped = 1'b1;
        end
        tests_run++;
        if (dropped) begin tests_failed++; $display("[TB] FAIL freeze_hold: owned %b want 1 while E stopped", bus.o_bus_owned); end
        e_run = 1'b1;
        start = efall_cnt;
        wait_owned(1'b0, to);
        n = efall_cnt - start;
        tests_run++;
        if (to || n != MAX_BURST - 5) begin tests_failed++; $display("[TB] FAIL freeze_resume: got %0d E falls want %0d", n, MAX_BURST - 5); end
        req = '0;
        wait_efalls(4);
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_req_drop();
        test_timeout();
        test_ack_drop();
        test_reset_mid_grant();
        test_e_freeze();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
